// File: rtl/cmp_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the comparator-interface search controller.
//   - state_e   : search FSM states
//   - DEF_WIDTH : default operand width
//   - DEF_CNT_W : default probe-counter width (must hold DEF_WIDTH+1)
//   - DEF_MAX   : all-ones maximum operand value for the default width
// ----------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;
    localparam int DEF_MAX   = (1 << DEF_WIDTH) - 1;

endpackage

// File: rtl/cmp_search_ctrl.sv
// ----------------------------------------------------------------------------
// cmp_search_ctrl
//   Initiator side of the comparator interface. Drives the A operand of an
//   external combinational comparator and binary-searches for the unknown B
//   operand using the less/equal/greater answers. Reports the value found,
//   the number of probes issued and whether the comparator answered
//   inconsistently.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   begin a search (only looked at in IDLE)
//   less       in   comparator: A < B
//   equal      in   comparator: A == B
//   greater    in   comparator: A > B
//   Data_out_A out  registered probe value, to comparator Data_in_A
//   busy       out  high while probing (DRIVE/EVAL)
//   done       out  one-cycle completion pulse (good or error)
//   found      out  final probe value, held until the next start
//   steps      out  number of probes issued, held until the next start
//   error      out  inconsistent comparator answer, held until the next start
// ----------------------------------------------------------------------------
module cmp_search_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] Data_out_A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] found,
    output logic [CNT_W-1:0] steps,
    output logic             error
);

    localparam logic [WIDTH-1:0] MAX_V     = '1;
    localparam logic [CNT_W-1:0] MAX_STEPS = CNT_W'(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] found_q, found_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             error_q, error_d;
    logic             one_hot;

    // Exactly one flag: odd population (XOR) but not all three.
    assign one_hot = (less ^ equal ^ greater) & ~(less & equal & greater);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= MAX_V;
            a_q     <= '0;
            found_q <= '0;
            steps_q <= '0;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            a_q     <= a_d;
            found_q <= found_d;
            steps_q <= steps_d;
            error_q <= error_d;
        end
    end

    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        a_d     = a_q;
        found_d = found_q;
        steps_d = steps_q;
        error_d = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d    = '0;
                    hi_d    = MAX_V;
                    steps_d = '0;
                    error_d = 1'b0;
                    state_d = DRIVE;
                end
            end

            DRIVE: begin
                // Sum carried in WIDTH+1 bits so lo+hi cannot wrap before
                // the halving shift.
                a_d     = WIDTH'(({1'b0, lo_q} + {1'b0, hi_q}) >> 1);
                steps_d = steps_q + CNT_W'(1);
                state_d = EVAL;
            end

            EVAL: begin
                // Any exit from EVAL ends the search on the current probe.
                found_d = a_q;
                state_d = DONE;
                if (!one_hot) begin
                    error_d = 1'b1;
                end else if (equal) begin
                    error_d = 1'b0;
                end else if (steps_q == MAX_STEPS) begin
                    // A monotone comparator always converges within
                    // WIDTH+1 probes; running out means it is not.
                    error_d = 1'b1;
                end else if (less) begin
                    if (a_q == MAX_V) begin
                        error_d = 1'b1;
                    end else begin
                        lo_d    = a_q + WIDTH'(1);
                        found_d = found_q;
                        state_d = DRIVE;
                    end
                end else begin
                    if (a_q == '0) begin
                        error_d = 1'b1;
                    end else begin
                        hi_d    = a_q - WIDTH'(1);
                        found_d = found_q;
                        state_d = DRIVE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Data_out_A = a_q;
    assign busy       = (state_q == DRIVE) || (state_q == EVAL);
    assign done       = (state_q == DONE);
    assign found      = found_q;
    assign steps      = steps_q;
    assign error      = error_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cmp_search_ctrl
//   Self-checking bench for cmp_search_ctrl. A behavioural comparator answers
//   the DUT probes; a reference binary search computes the expected probe
//   sequence, probe count, result and error flag.
// ----------------------------------------------------------------------------
module tb_cmp_search_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int MAXV  = (1 << WIDTH) - 1;

    // Comparator behaviour: normal, both less and greater, always less.
    localparam int M_NORMAL = 0;
    localparam int M_BOTH   = 1;
    localparam int M_LESS   = 2;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             less;
    logic             equal;
    logic             greater;
    logic [WIDTH-1:0] Data_out_A;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] found;
    logic [CNT_W-1:0] steps;
    logic             error;

    int b_val;
    int mode;

    int n_checks;
    int n_fails;

    int exp_probes[$];
    int exp_found;
    int exp_steps;
    bit exp_err;
    bit exp_found_valid;

    cmp_search_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .less       (less),
        .equal      (equal),
        .greater    (greater),
        .Data_out_A (Data_out_A),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .steps      (steps),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Comparator answer {less, equal, greater} for probe a against b.
    function automatic logic [2:0] resp(input int a, input int b, input int m);
        case (m)
            M_BOTH:  return 3'b101;
            M_LESS:  return 3'b100;
            default: return {a < b, a == b, a > b};
        endcase
    endfunction

    always_comb begin
        {less, equal, greater} = resp(int'(Data_out_A), b_val, mode);
    end

    // Reference search: halve [lo,hi] until hit, flagging impossible answers.
    function automatic void model(input int b, input int m);
        int lo;
        int hi;
        int mid;
        logic [2:0] r;
        lo = 0;
        hi = MAXV;
        exp_probes.delete();
        exp_err = 1'b0;
        exp_found_valid = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            mid = (lo + hi) / 2;
            exp_probes.push_back(mid);
            exp_found = mid;
            exp_steps = n;
            r = resp(mid, b, m);
            if ($countones(r) != 1) begin
                exp_err = 1'b1;
                break;
            end
            if (r[1]) break;
            if (n == WIDTH + 1) begin
                exp_err = 1'b1;
                exp_found_valid = 1'b0;
                break;
            end
            if (r[2]) begin
                if (mid == MAXV) begin
                    exp_err = 1'b1;
                    exp_found_valid = 1'b0;
                    break;
                end
                lo = mid + 1;
            end else begin
                if (mid == 0) begin
                    exp_err = 1'b1;
                    exp_found_valid = 1'b0;
                    break;
                end
                hi = mid - 1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full search. Start is sampled at the first edge; the bench then
    // follows the DUT cycle by cycle against the reference search.
    task automatic run_search(input int b, input int m, input bit hold, input bit glitch);
        int p;
        int waited;
        b_val = b;
        mode  = m;
        model(b, m);
        p = exp_probes.size();
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 2 * p; c++) begin
            tick();
            if (glitch) start = (c < 2 * p) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (c % 2 == 1)
                check($sformatf("probe%0d_b%0d", (c - 1) / 2, b), 32'(Data_out_A), 32'(exp_probes[(c - 1) / 2]));
            check($sformatf("done_c%0d_b%0d", c, b), 32'(done), 32'(c == 2 * p));
            check($sformatf("busy_c%0d_b%0d", c, b), 32'(busy), 32'(c != 2 * p));
        end
        check($sformatf("steps_b%0d_m%0d", b, m), 32'(steps), 32'(exp_steps));
        check($sformatf("error_b%0d_m%0d", b, m), 32'(error), 32'(exp_err));
        if (exp_found_valid)
            check($sformatf("found_b%0d_m%0d", b, m), 32'(found), 32'(exp_found));
        tick();
        check($sformatf("done_low_b%0d", b), 32'(done), 32'd0);
        check($sformatf("idle_b%0d", b), 32'(busy), 32'd0);
        check($sformatf("hold_a_b%0d", b), 32'(Data_out_A), 32'(exp_probes[p - 1]));
        if (hold) begin
            // Start still high: the IDLE edge launches a new search.
            tick();
            check("restart_busy", 32'(busy), 32'd1);
            start = 1'b0;
            tick();
            check("restart_probe", 32'(Data_out_A), 32'(exp_probes[0]));
            waited = 0;
            while (!done && waited < 40) begin
                tick();
                waited++;
            end
            check("restart_done_seen", 32'(done), 32'd1);
            check("restart_found", 32'(found), 32'(exp_found));
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        b_val    = 0;
        mode     = M_NORMAL;
        tick();
        tick();

        // Reset state
        check("rst_a", 32'(Data_out_A), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_steps", 32'(steps), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed searches
        run_search(10, M_NORMAL, 1'b0, 1'b0);
        run_search(15, M_NORMAL, 1'b0, 1'b0);
        run_search(0,  M_NORMAL, 1'b0, 1'b0);
        run_search(12, M_NORMAL, 1'b1, 1'b0);

        // Faulty comparator answers
        run_search(5, M_BOTH, 1'b0, 1'b0);
        run_search(5, M_LESS, 1'b0, 1'b0);

        // Reset during the second EVAL
        b_val = 9;
        mode  = M_NORMAL;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_a", 32'(Data_out_A), 32'd0);
        check("midrst_steps", 32'(steps), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_error", 32'(error), 32'd0);
        tick();
        check("midrst_no_done", 32'(done), 32'd0);
        check("midrst_still_idle", 32'(busy), 32'd0);
        run_search(9, M_NORMAL, 1'b0, 1'b0);

        // Random targets with start toggling while busy
        for (int i = 0; i < 12; i++) begin
            run_search(int'($urandom_range(0, MAXV)), M_NORMAL, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
